// File: rtl/hpdcache_l15_req_arbiter.sv
// Round-robin arbiter merging N requester ports onto one L1.5 adapter request
// channel, with the grant locked while backpressured, plus a pid-routed response demux.
module hpdcache_l15_req_arbiter #(
    parameter int N      = 5,
    parameter int REQ_W  = 128,
    parameter int RESP_W = 264,
    parameter int PID_W  = 3
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,

    input  logic [N-1:0]         req_valid_i,
    output logic [N-1:0]         req_ready_o,
    input  logic [N*REQ_W-1:0]   req_i,

    output logic                 arb_valid_o,
    input  logic                 arb_ready_i,
    output logic [REQ_W-1:0]     arb_req_o,
    output logic [N-1:0]         arb_index_o,
    output logic [PID_W-1:0]     arb_pid_o,

    input  logic                 resp_valid_i,
    output logic                 resp_ready_o,
    input  logic [PID_W-1:0]     resp_pid_i,
    input  logic [RESP_W-1:0]    resp_i,

    output logic [N-1:0]         resp_valid_o,
    input  logic [N-1:0]         resp_ready_i,
    output logic [RESP_W-1:0]    resp_o,
    output logic                 pid_err_o
);

    localparam logic [PID_W:0]   N_EXT    = (PID_W+1)'(N);
    localparam logic [PID_W-1:0] LAST_PID = PID_W'(N-1);

    logic [PID_W-1:0] r_ptr;
    logic [PID_W-1:0] r_gnt;
    logic             r_lock;
    logic             r_pid_err;

    logic [2*N-1:0]   w_rot;
    logic [PID_W:0]   w_sum;
    logic [PID_W-1:0] w_rr_gnt;
    logic             w_any;
    logic [PID_W-1:0] w_gnt;
    logic [PID_W-1:0] w_gnt_inc;
    logic             w_valid;
    logic             w_hs;
    logic             w_pid_ok;
    logic             w_port_ready;

    // Rotate the valids so bit 0 is the pointer position; the first set bit
    // i maps back to port (ptr + i) mod N.
    always_comb begin
        w_rot    = {req_valid_i, req_valid_i} >> r_ptr;
        w_rr_gnt = '0;
        w_any    = 1'b0;
        w_sum    = '0;
        for (int i = 0; i < N; i++) begin
            if (!w_any && w_rot[i]) begin
                w_any = 1'b1;
                w_sum = {1'b0, r_ptr} + (PID_W+1)'(i);
                if (w_sum >= N_EXT) begin
                    w_sum = w_sum - N_EXT;
                end
                w_rr_gnt = w_sum[PID_W-1:0];
            end
        end
    end

    // A locked grant is presented even if the requester illegally drops valid.
    assign w_gnt     = r_lock ? r_gnt : w_rr_gnt;
    assign w_valid   = r_lock | w_any;
    assign w_hs      = w_valid & arb_ready_i;
    assign w_gnt_inc = (w_gnt == LAST_PID) ? '0 : w_gnt + 1'b1;

    assign arb_valid_o = w_valid;
    assign arb_pid_o   = w_valid ? w_gnt : '0;
    assign arb_req_o   = req_i[int'(w_gnt)*REQ_W +: REQ_W];

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_port
            assign arb_index_o[gi]  = w_valid && (w_gnt == PID_W'(gi));
            assign req_ready_o[gi]  = arb_ready_i && arb_index_o[gi];
            assign resp_valid_o[gi] = resp_valid_i && (resp_pid_i == PID_W'(gi));
        end
    endgenerate

    assign w_pid_ok = {1'b0, resp_pid_i} < N_EXT;

    always_comb begin
        w_port_ready = 1'b0;
        for (int k = 0; k < N; k++) begin
            if (resp_pid_i == PID_W'(k)) begin
                w_port_ready = resp_ready_i[k];
            end
        end
    end

    // Out-of-range ids are acknowledged so the adapter never stalls on them.
    assign resp_ready_o = w_pid_ok ? w_port_ready : 1'b1;
    assign resp_o       = resp_i;
    assign pid_err_o    = r_pid_err;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_ptr     <= '0;
            r_gnt     <= '0;
            r_lock    <= 1'b0;
            r_pid_err <= 1'b0;
        end else begin
            if (w_hs) begin
                r_lock <= 1'b0;
                r_ptr  <= w_gnt_inc;
            end else if (w_valid) begin
                r_lock <= 1'b1;
                r_gnt  <= w_gnt;
            end
            if (resp_valid_i && !w_pid_ok) begin
                r_pid_err <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_hpdcache_l15_req_arbiter.sv
// Self-checking bench for hpdcache_l15_req_arbiter: vector table plus
// hand-written lock, wrap, bad-pid and reset sequences, checked via a queue.
module tb_hpdcache_l15_req_arbiter;

    localparam int N      = 5;
    localparam int REQ_W  = 128;
    localparam int RESP_W = 264;
    localparam int PID_W  = 3;

    logic                 clk_i;
    logic                 rst_ni;
    logic [N-1:0]         req_valid_i;
    logic [N-1:0]         req_ready_o;
    logic [N*REQ_W-1:0]   req_i;
    logic                 arb_valid_o;
    logic                 arb_ready_i;
    logic [REQ_W-1:0]     arb_req_o;
    logic [N-1:0]         arb_index_o;
    logic [PID_W-1:0]     arb_pid_o;
    logic                 resp_valid_i;
    logic                 resp_ready_o;
    logic [PID_W-1:0]     resp_pid_i;
    logic [RESP_W-1:0]    resp_i;
    logic [N-1:0]         resp_valid_o;
    logic [N-1:0]         resp_ready_i;
    logic [RESP_W-1:0]    resp_o;
    logic                 pid_err_o;

    hpdcache_l15_req_arbiter #(
        .N(N), .REQ_W(REQ_W), .RESP_W(RESP_W), .PID_W(PID_W)
    ) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_i(req_i),
        .arb_valid_o(arb_valid_o), .arb_ready_i(arb_ready_i), .arb_req_o(arb_req_o),
        .arb_index_o(arb_index_o), .arb_pid_o(arb_pid_o),
        .resp_valid_i(resp_valid_i), .resp_ready_o(resp_ready_o),
        .resp_pid_i(resp_pid_i), .resp_i(resp_i),
        .resp_valid_o(resp_valid_o), .resp_ready_i(resp_ready_i), .resp_o(resp_o),
        .pid_err_o(pid_err_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [N-1:0] rv;
        logic         ar;
        logic [N-1:0] idx;
        logic         rsv;
        logic [PID_W-1:0] rpid;
        logic [N-1:0] rrdy;
    } vec_t;

    typedef struct {
        string            name;
        logic             valid;
        logic [N-1:0]     idx;
        logic [PID_W-1:0] pid;
        logic [N-1:0]     rdy;
        logic [REQ_W-1:0] req;
        logic [N-1:0]     rvo;
        logic             rro;
        logic [RESP_W-1:0] resp;
        logic             err;
    } exp_t;

    exp_t sb_q[$];
    vec_t tbl[7];
    int   total = 0;
    int   bad   = 0;
    logic exp_err = 1'b0;

    function automatic logic [REQ_W-1:0] payload(input int k);
        return REQ_W'(64'hC0DE_0000_0000_0000 + 64'(k) * 64'h1_0001);
    endfunction

    task automatic chk(input string tag, input string field,
                       input logic [RESP_W-1:0] act, input logic [RESP_W-1:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s.%s act=%0h exp=%0h", tag, field, act, exp);
        end
    endtask

    // Drive one cycle, push the model's expectation, compare away from the edge.
    task automatic step(input string name, input logic [N-1:0] rv, input logic ar,
                        input logic [N-1:0] exp_idx, input logic rsv,
                        input logic [PID_W-1:0] rpid, input logic [N-1:0] rrdy);
        exp_t e;
        exp_t g;
        req_valid_i  = rv;
        arb_ready_i  = ar;
        resp_valid_i = rsv;
        resp_pid_i   = rpid;
        resp_ready_i = rrdy;
        for (int b = 0; b < RESP_W; b++) resp_i[b] = 1'($urandom_range(0, 1));

        e.name  = name;
        e.idx   = exp_idx;
        e.valid = (exp_idx != '0);
        e.pid   = '0;
        for (int k = 0; k < N; k++) if (exp_idx[k]) e.pid = PID_W'(k);
        e.rdy   = ar ? exp_idx : '0;
        e.req   = payload(int'(e.pid));
        if (int'(rpid) < N) begin
            e.rvo = rsv ? (N'(1) << rpid) : '0;
            e.rro = rrdy[rpid];
        end else begin
            e.rvo = '0;
            e.rro = 1'b1;
        end
        e.resp = resp_i;
        e.err  = exp_err;
        sb_q.push_back(e);

        @(negedge clk_i);
        if (sb_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL %s.queue act=empty exp=entry", name);
        end else begin
            g = sb_q.pop_front();
            chk(g.name, "arb_valid", RESP_W'(arb_valid_o), RESP_W'(g.valid));
            chk(g.name, "arb_index", RESP_W'(arb_index_o), RESP_W'(g.idx));
            chk(g.name, "arb_pid", RESP_W'(arb_pid_o), RESP_W'(g.pid));
            chk(g.name, "req_ready", RESP_W'(req_ready_o), RESP_W'(g.rdy));
            if (g.valid) chk(g.name, "arb_req", RESP_W'(arb_req_o), RESP_W'(g.req));
            chk(g.name, "resp_valid", RESP_W'(resp_valid_o), RESP_W'(g.rvo));
            chk(g.name, "resp_ready", RESP_W'(resp_ready_o), RESP_W'(g.rro));
            chk(g.name, "resp_o", resp_o, g.resp);
            chk(g.name, "pid_err", RESP_W'(pid_err_o), RESP_W'(g.err));
        end
        @(posedge clk_i);
        #1;
        if (rsv && int'(rpid) >= N) exp_err = 1'b1;
    endtask

    task automatic clear_inputs();
        req_valid_i  = '0;
        arb_ready_i  = 1'b0;
        resp_valid_i = 1'b0;
        resp_pid_i   = '0;
        resp_ready_i = '0;
        resp_i       = '0;
    endtask

    task automatic chk_zero(input string tag);
        chk(tag, "arb_valid", RESP_W'(arb_valid_o), '0);
        chk(tag, "arb_index", RESP_W'(arb_index_o), '0);
        chk(tag, "arb_pid", RESP_W'(arb_pid_o), '0);
        chk(tag, "req_ready", RESP_W'(req_ready_o), '0);
        chk(tag, "resp_valid", RESP_W'(resp_valid_o), '0);
        chk(tag, "resp_ready", RESP_W'(resp_ready_o), '0);
        chk(tag, "resp_o", resp_o, '0);
        chk(tag, "pid_err", RESP_W'(pid_err_o), '0);
    endtask

    task automatic do_reset(input string tag);
        clear_inputs();
        rst_ni = 1'b0;
        #2;
        chk_zero(tag);
        @(posedge clk_i);
        @(posedge clk_i);
        #1;
        chk_zero(tag);
        exp_err = 1'b0;
        rst_ni  = 1'b1;
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        tbl[0] = '{rv: 5'b00000, ar: 1'b0, idx: 5'b00000, rsv: 1'b0, rpid: 3'd0, rrdy: 5'b00000};
        tbl[1] = '{rv: 5'b11111, ar: 1'b1, idx: 5'b00001, rsv: 1'b1, rpid: 3'd3, rrdy: 5'b01000};
        tbl[2] = '{rv: 5'b11111, ar: 1'b1, idx: 5'b00010, rsv: 1'b1, rpid: 3'd3, rrdy: 5'b10111};
        tbl[3] = '{rv: 5'b00001, ar: 1'b1, idx: 5'b00001, rsv: 1'b0, rpid: 3'd0, rrdy: 5'b00001};
        tbl[4] = '{rv: 5'b10100, ar: 1'b1, idx: 5'b00100, rsv: 1'b1, rpid: 3'd4, rrdy: 5'b10000};
        tbl[5] = '{rv: 5'b10100, ar: 1'b1, idx: 5'b10000, rsv: 1'b1, rpid: 3'd1, rrdy: 5'b00000};
        tbl[6] = '{rv: 5'b10010, ar: 1'b1, idx: 5'b00010, rsv: 1'b0, rpid: 3'd0, rrdy: 5'b00000};

        req_i = '0;
        for (int k = 0; k < N; k++) req_i[k*REQ_W +: REQ_W] = payload(k);

        do_reset("reset0");
        for (int i = 0; i < 7; i++) begin
            step($sformatf("vec%0d", i), tbl[i].rv, tbl[i].ar, tbl[i].idx,
                 tbl[i].rsv, tbl[i].rpid, tbl[i].rrdy);
        end

        do_reset("reset1");
        for (int c = 0; c < 2*N; c++) begin
            step($sformatf("rot%0d", c), 5'b11111, 1'b1, N'(1) << (c % N),
                 1'b0, 3'd0, 5'b00000);
        end

        step("lock_c1", 5'b00100, 1'b0, 5'b00100, 1'b0, 3'd0, 5'b00000);
        step("lock_c2", 5'b00101, 1'b0, 5'b00100, 1'b0, 3'd0, 5'b00000);
        step("lock_c3", 5'b00101, 1'b0, 5'b00100, 1'b0, 3'd0, 5'b00000);
        step("lock_acc", 5'b00101, 1'b1, 5'b00100, 1'b0, 3'd0, 5'b00000);
        step("ptr3", 5'b11111, 1'b0, 5'b01000, 1'b0, 3'd0, 5'b00000);
        step("lock_drop", 5'b00000, 1'b0, 5'b01000, 1'b0, 3'd0, 5'b00000);
        step("lock_rel", 5'b01000, 1'b1, 5'b01000, 1'b0, 3'd0, 5'b00000);
        step("wrap", 5'b00001, 1'b1, 5'b00001, 1'b0, 3'd0, 5'b00000);
        step("after_wrap", 5'b11111, 1'b1, 5'b00010, 1'b0, 3'd0, 5'b00000);

        step("badpid", 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd6, 5'b00000);
        step("err_hold1", 5'b00000, 1'b0, 5'b00000, 1'b0, 3'd0, 5'b00000);
        step("err_hold2", 5'b00000, 1'b0, 5'b00000, 1'b1, 3'd5, 5'b11111);

        step("rl_lock", 5'b10000, 1'b0, 5'b10000, 1'b0, 3'd0, 5'b00000);
        step("rl_hold", 5'b10010, 1'b0, 5'b10000, 1'b0, 3'd0, 5'b00000);
        do_reset("rl_reset");
        step("rl_first", 5'b10010, 1'b1, 5'b00010, 1'b0, 3'd0, 5'b00000);
        step("rl_second", 5'b10000, 1'b1, 5'b10000, 1'b0, 3'd0, 5'b00000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
